// File: rtl/instr_assembler_pkg.sv
// Shared types, constants and helpers for the instruction assembler.
//   XLEN           : datapath / instruction width
//   imm_fmt_t      : instruction format selector (6 and 7 are illegal)
//   OP_*           : RV32I opcodes commonly fed to the assembler
//   fields_t       : one symbolic field bundle as captured by the first stage
//   imm_range_err  : immediate range / alignment check for a given format
package instr_assembler_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_t;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6f;

    typedef struct packed {
        logic [2:0]      fmt;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
    } fields_t;

    // An immediate fits a signed N-bit field when every bit from N-1 upward
    // equals the sign, i.e. the slice is all zeros or all ones.
    function automatic logic imm_range_err(logic [2:0] fmt, logic [XLEN-1:0] imm);
        logic err;
        err = 1'b0;
        case (fmt)
            FMT_R:        err = 1'b0;
            FMT_I, FMT_S: err = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            FMT_U:        err = |imm[11:0];
            FMT_J:        err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Handshake bundle between the loader, the assembler and the instruction-memory
// write port.
//   in_*      : symbolic field bundle with valid/ready
//   out_*     : packed instruction word, its byte address and range-error flag
// Modports:
//   master : loader side (drives fields, consumes words)
//   slave  : assembler side
interface instr_assembler_if #(
    parameter int unsigned BITS   = 32,
    parameter int unsigned ADDR_W = 16
) ();

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [BITS-1:0]   in_imm;

    logic              out_valid;
    logic              out_ready;
    logic [BITS-1:0]   out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );

endinterface

// File: rtl/instr_assembler_imm_pack.sv
// Combinational packer: turns a symbolic field bundle into an RV32I word.
//   fields : format, opcode, register/function fields and signed immediate
//   instr  : packed instruction word (zero for an illegal format)
//   err    : immediate out of range / misaligned for the format, or illegal
//            format; the word is still built from the truncated immediate bits
module instr_assembler_imm_pack
    import instr_assembler_pkg::*;
(
    input  fields_t         fields,
    output logic [XLEN-1:0] instr,
    output logic            err
);

    always_comb begin
        instr = '0;
        err   = imm_range_err(fields.fmt, fields.imm);
        case (fields.fmt)
            FMT_R: instr = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                            fields.rd, fields.opcode};
            FMT_I: instr = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd,
                            fields.opcode};
            FMT_S: instr = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                            fields.imm[4:0], fields.opcode};
            FMT_B: instr = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                            fields.funct3, fields.imm[4:1], fields.imm[11],
                            fields.opcode};
            FMT_U: instr = {fields.imm[31:12], fields.rd, fields.opcode};
            FMT_J: instr = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                            fields.imm[19:12], fields.rd, fields.opcode};
            default: instr = '0;
        endcase
    end

endmodule

// File: rtl/instr_assembler.sv
// Instruction assembler: accepts symbolic RV32I fields from the loader and
// emits packed words with sequential byte addresses toward instruction memory.
// Two-stage pipeline: S1 holds the fields plus range-check result, S2 holds
// the packed word. Handshake-to-output latency is 2 cycles, 1 word/cycle.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset, flushes both stages
//   bus      : field/word handshake bundle (slave side)
//   addr_clr : synchronous restart of the address sequence at BASE_ADDR
//   err_cnt  : saturating count of erroneous words handed off downstream
module instr_assembler
    import instr_assembler_pkg::*;
#(
    parameter int unsigned       BITS      = XLEN,
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_assembler_if.slave     bus,
    input  logic                 addr_clr,
    output logic [7:0]           err_cnt
);

    // Handshake / ready chain
    logic s1_valid_q;
    logic s2_valid_q;
    logic s1_ready;
    logic s2_ready;
    logic out_fire;

    // Ready propagates backward combinationally so a full pipe still moves
    // one word per cycle when the consumer is ready.
    assign s2_ready     = !s2_valid_q || bus.out_ready;
    assign s1_ready     = !s1_valid_q || s2_ready;
    assign bus.in_ready = s1_ready;
    assign out_fire     = s2_valid_q && bus.out_ready;

    // Stage 1: captured fields and range check
    fields_t in_fields;
    fields_t s1_fields_q;
    logic    s1_err_q;

    always_comb begin
        in_fields        = '0;
        in_fields.fmt    = bus.in_fmt;
        in_fields.opcode = bus.in_opcode;
        in_fields.rd     = bus.in_rd;
        in_fields.rs1    = bus.in_rs1;
        in_fields.rs2    = bus.in_rs2;
        in_fields.funct3 = bus.in_funct3;
        in_fields.funct7 = bus.in_funct7;
        in_fields.imm    = bus.in_imm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fields_q <= '0;
            s1_err_q    <= 1'b0;
        end else if (s1_ready) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_fields_q <= in_fields;
                s1_err_q    <= imm_range_err(bus.in_fmt, bus.in_imm);
            end
        end
    end

    // Packing between S1 and S2
    logic [BITS-1:0] pack_instr;
    logic            pack_err;

    instr_assembler_imm_pack u_imm_pack (
        .fields (s1_fields_q),
        .instr  (pack_instr),
        .err    (pack_err)
    );

`ifndef SYNTHESIS
    // The early check in S1 and the packer's own check must agree.
    always_comb begin
        if (s1_valid_q) begin
            assert (pack_err == s1_err_q);
        end
    end
`endif

    // Stage 2: packed word
    logic [BITS-1:0] s2_instr_q;
    logic            s2_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_q <= pack_instr;
                s2_err_q   <= s1_err_q;
            end
        end
    end

    // Output address and error counter
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        err_cnt_q;
    logic [7:0]        err_cnt_d;

    always_comb begin
        addr_d = addr_q;
        // Clear wins over the increment of a simultaneous handshake.
        if (addr_clr) begin
            addr_d = BASE_ADDR;
        end else if (out_fire) begin
            addr_d = addr_q + ADDR_W'(4);
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_fire && s2_err_q && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= BASE_ADDR;
            err_cnt_q <= 8'd0;
        end else begin
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_instr = s2_instr_q;
    assign bus.out_err   = s2_err_q;
    assign bus.out_addr  = addr_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Self-checking bench for instr_assembler: directed scenarios plus randomized
// traffic compared against a behavioural packing/range/address model.
module tb_instr_assembler;

    localparam logic [15:0] BASE = 16'h0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       addr_clr = 1'b0;
    logic [7:0] err_cnt;

    instr_assembler_if #(.BITS(32), .ADDR_W(16)) bus ();

    instr_assembler #(.BITS(32), .ADDR_W(16), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .addr_clr (addr_clr),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] addr;
        logic        err;
        int          cyc;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } exp_t;

    obs_t        obs_q[$];
    obs_t        got_q[$];
    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          exp_errs = 0;
    logic [15:0] exp_addr = BASE;
    bit          rand_run = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output handshake; sampled mid-cycle, the edge follows.
    always @(negedge clk) begin
        obs_t o;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            o.instr = bus.out_instr;
            o.addr  = bus.out_addr;
            o.err   = bus.out_err;
            o.cyc   = cyc;
            obs_q.push_back(o);
        end
    end

    // Reference: fields placed by shifting/masking, range by signed bounds.
    function automatic void ref_pack(input logic [2:0] fmt, input logic [6:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] imm,
                                     output logic [31:0] w, output logic e);
        int s;
        logic [31:0] base_rs;
        s = $signed(imm);
        base_rs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        w = 32'h0;
        e = 1'b0;
        case (fmt)
            3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | base_rs | (32'(rd) << 7);
            3'd1: begin
                e = (s < -2048) || (s > 2047);
                w = ((imm & 32'hfff) << 20) | base_rs | (32'(rd) << 7);
            end
            3'd2: begin
                e = (s < -2048) || (s > 2047);
                w = (((imm >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | base_rs
                    | ((imm & 32'h1f) << 7);
            end
            3'd3: begin
                e = (s < -4096) || (s > 4095) || ((imm & 32'h1) != 0);
                w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25)
                    | (32'(rs2) << 20) | base_rs | (((imm >> 1) & 32'hf) << 8)
                    | (((imm >> 11) & 32'h1) << 7);
            end
            3'd4: begin
                e = (imm & 32'hfff) != 0;
                w = (imm & 32'hfffff000) | (32'(rd) << 7) | 32'(op);
            end
            3'd5: begin
                e = (s < -(1 << 20)) || (s > (1 << 20) - 1) || ((imm & 32'h1) != 0);
                w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
                    | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hff) << 12)
                    | (32'(rd) << 7) | 32'(op);
            end
            default: begin
                w = 32'h0;
                e = 1'b1;
            end
        endcase
    endfunction

    // Present one bundle until accepted; enters and leaves just after posedge.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        exp_t e;
        int   n;
        bit   acc;
        n = 0;
        acc = 1'b0;
        bus.in_fmt = fmt;
        bus.in_opcode = op;
        bus.in_rd = rd;
        bus.in_rs1 = rs1;
        bus.in_rs2 = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm = imm;
        bus.in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) last_acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_accept: in_ready low for %0d cycles, required accept", n);
        end else begin
            ref_pack(fmt, op, rd, rs1, rs2, f3, f7, imm, e.instr, e.err);
            e.cyc = last_acc_cyc;
            exp_q.push_back(e);
        end
    endtask

    // Let every expected word out and compare against the model in order.
    task automatic drain(input string name, input int clr_after);
        int   n;
        int   i;
        int   want;
        obs_t o;
        exp_t e;
        n = 0;
        i = 0;
        want = exp_q.size();
        got_q.delete();
        bus.out_ready = 1'b1;
        while (obs_q.size() < want && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() != want) begin
            errors++;
            $display("FAIL %s_count: got %0d words, required %0d", name, obs_q.size(), want);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            got_q.push_back(o);
            checks++;
            if (o.instr !== e.instr) begin
                errors++;
                $display("FAIL %s_instr[%0d]: got %08h, required %08h", name, i, o.instr,
                         e.instr);
            end
            checks++;
            if (o.err !== e.err) begin
                errors++;
                $display("FAIL %s_err[%0d]: got %0b, required %0b", name, i, o.err, e.err);
            end
            checks++;
            if (o.addr !== exp_addr) begin
                errors++;
                $display("FAIL %s_addr[%0d]: got %04h, required %04h", name, i, o.addr,
                         exp_addr);
            end
            exp_addr = exp_addr + 16'd4;
            if (i == clr_after) exp_addr = BASE;
            if (e.err && exp_errs < 255) exp_errs++;
            i++;
        end
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (err_cnt !== 8'(exp_errs)) begin
            errors++;
            $display("FAIL %s_err_cnt: got %0d, required %0d", name, err_cnt, exp_errs);
        end
    endtask

    task automatic pulse_clr();
        addr_clr = 1'b1;
        @(posedge clk);
        #1;
        addr_clr = 1'b0;
        exp_addr = BASE;
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %b, required 1", name, bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_out_valid: got %b, required 0", name, bus.out_valid);
        end
        checks++;
        if (bus.out_instr !== 32'h0) begin
            errors++;
            $display("FAIL %s_out_instr: got %08h, required 0", name, bus.out_instr);
        end
        checks++;
        if (bus.out_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_out_err: got %b, required 0", name, bus.out_err);
        end
        checks++;
        if (bus.out_addr !== BASE) begin
            errors++;
            $display("FAIL %s_out_addr: got %04h, required %04h", name, bus.out_addr, BASE);
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL %s_err_cnt: got %0d, required 0", name, err_cnt);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_fmt = 3'd0;
        bus.in_opcode = 7'd0;
        bus.in_rd = 5'd0;
        bus.in_rs1 = 5'd0;
        bus.in_rs2 = 5'd0;
        bus.in_funct3 = 3'd0;
        bus.in_funct7 = 7'd0;
        bus.in_imm = 32'd0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("post_reset");
        exp_addr = BASE;
        exp_errs = 0;
    endtask

    task automatic test_itype();
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hffff_ffff);
        drain("itype", -1);
        checks++;
        if (got_q.size() < 1 || got_q[0].instr !== 32'hfff0_0093 || got_q[0].addr !== 16'h0) begin
            errors++;
            $display("FAIL itype_vector: got %0d words first %08h@%04h, required fff00093@0000",
                     got_q.size(), got_q.size() > 0 ? got_q[0].instr : 32'h0,
                     got_q.size() > 0 ? got_q[0].addr : 16'h0);
        end
        checks++;
        if (got_q.size() < 1 || got_q[0].cyc - last_acc_cyc != 2) begin
            errors++;
            $display("FAIL itype_latency: got %0d cycles, required 2",
                     got_q.size() > 0 ? got_q[0].cyc - last_acc_cyc : -1);
        end
    endtask

    task automatic test_back_to_back();
        pulse_clr();
        send(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hffff_fffc);
        drain("s_b", -1);
        checks++;
        if (got_q.size() < 2 || got_q[0].instr !== 32'h0021_a423 || got_q[1].instr !== 32'hfe00_0ee3
            || got_q[1].addr !== 16'h0004) begin
            errors++;
            $display("FAIL s_b_vector: got %0d words, required 0021a423@0000 fe000ee3@0004",
                     got_q.size());
        end
        checks++;
        if (got_q.size() < 2 || got_q[1].cyc != got_q[0].cyc + 1) begin
            errors++;
            $display("FAIL s_b_consecutive: got cycle gap %0d, required 1",
                     got_q.size() > 1 ? got_q[1].cyc - got_q[0].cyc : -1);
        end
    endtask

    task automatic test_jtype();
        send(3'd5, 7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        drain("jtype", -1);
        checks++;
        if (got_q.size() < 1 || got_q[0].instr !== 32'h0010_00ef || got_q[0].err !== 1'b0) begin
            errors++;
            $display("FAIL jtype_vector: got %08h, required 001000ef err 0",
                     got_q.size() > 0 ? got_q[0].instr : 32'h0);
        end
    endtask

    task automatic test_range_err();
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0003);
        drain("range", -1);
        checks++;
        if (got_q.size() < 2 || got_q[0].instr !== 32'h8000_0093 || got_q[0].err !== 1'b1
            || got_q[1].err !== 1'b1) begin
            errors++;
            $display("FAIL range_vector: got %0d words, required 80000093 err 1 then err 1",
                     got_q.size());
        end
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL range_err_cnt: got %0d, required 2", err_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        pulse_clr();
        bus.out_ready = 1'b0;
        send(3'd0, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'd0);
        send(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd100);
        bus.in_fmt = 3'd4;
        bus.in_opcode = 7'h37;
        bus.in_rd = 5'd9;
        bus.in_imm = 32'h1234_5000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        held = bus.out_instr;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %b, required 0", bus.in_ready);
        end
        checks++;
        if (exp_q.size() < 1 || held !== exp_q[0].instr || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_head: got %08h valid %b, required first word valid", held,
                     bus.out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_instr !== held || bus.out_addr !== BASE || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stable[%0d]: got %08h@%04h rdy %b, required %08h@%04h rdy 0",
                         k, bus.out_instr, bus.out_addr, bus.in_ready, held, BASE);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(3'd4, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        drain("bp", -1);
        checks++;
        if (got_q.size() != 3 || got_q[0].addr !== 16'h0 || got_q[1].addr !== 16'h4
            || got_q[2].addr !== 16'h8) begin
            errors++;
            $display("FAIL bp_addrs: got %0d words, required 3 at 0000 0004 0008", got_q.size());
        end
    endtask

    task automatic test_addr_clr();
        bus.out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd3, 5'd3, 5'd0, 3'd0, 7'd0, 32'hffff_f800);
        send(3'd1, 7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'd7);
        // First word leaves on the same edge that clears the address.
        bus.out_ready = 1'b1;
        addr_clr = 1'b1;
        @(posedge clk);
        #1;
        addr_clr = 1'b0;
        drain("clr", 0);
        checks++;
        if (got_q.size() != 2 || got_q[0].addr !== 16'h000c || got_q[1].addr !== BASE) begin
            errors++;
            $display("FAIL clr_addrs: got %0d words, required 000c then %04h", got_q.size(),
                     BASE);
        end
    endtask

    task automatic test_random();
        logic [31:0] imm;
        rand_run = 1'b1;
        fork
            begin
                while (rand_run) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 3))
                0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: imm = $urandom;
                2: imm = $urandom & 32'hffff_f000;
                default: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
            endcase
            send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 7'($urandom), imm);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drain("rand", -1);
    endtask

    task automatic test_err_saturate();
        for (int k = 0; k < 260; k++) begin
            send(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        end
        drain("sat", -1);
        checks++;
        if (err_cnt !== 8'hff) begin
            errors++;
            $display("FAIL sat_err_cnt: got %0d, required 255", err_cnt);
        end
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd5);
        send(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd6);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full: got valid %b ready %b, required 1 0", bus.out_valid,
                     bus.in_ready);
        end
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        exp_addr = BASE;
        exp_errs = 0;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() != 0 || bus.out_valid !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_after: got %0d words valid %b err_cnt %0d, required 0 0 0",
                     obs_q.size(), bus.out_valid, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_itype();
        test_back_to_back();
        test_jtype();
        test_range_err();
        test_backpressure();
        test_addr_clr();
        test_random();
        test_err_saturate();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Inverse of the decode-side immediate generator: takes an instruction format, register/function fields and a 32-bit signed immediate, and packs them into an RV32I instruction word.
- Fields go in through a valid/ready handshake. Each packed word leaves through a valid/ready handshake together with a sequential byte address and a range-error flag.
- Sits between the host/UART loader and instruction-memory write port, so the loader can send symbolic fields instead of raw words.

Parameters:
- BITS, 32, datapath/instruction width (from common_params)
- ADDR_W, 16, width of emitted byte address
- BASE_ADDR, 0, address of first emitted word and value restored by addr_clr

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  block can accept bundle this cycle
- in_fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- in_opcode  input  7  opcode field
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R only)
- in_imm  input  BITS  signed immediate, byte offset for B/J, full value for U
- out_valid  output  1  packed word valid
- out_ready  input  1  consumer accepts word
- out_instr  output  BITS  packed instruction
- out_addr  output  ADDR_W  byte address of out_instr
- out_err  output  1  immediate failed range/alignment check
- addr_clr  input  1  synchronous restart of address sequence
- err_cnt  output  8  saturating count of accepted erroneous words

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_cnt=0. Both pipeline valids clear.
- Pipeline, two stages:
  - S1: registers fields plus a range-check result.
  - S2: registers the assembled word.
  - Latency from input handshake to out_valid is 2 cycles. Throughput is 1 word/cycle when out_ready=1.
- Ready chain, all combinational:
  - s2_ready = !s2_valid | out_ready
  - s1_ready = !s1_valid | s2_ready
  - in_ready = s1_ready
- No bundle is dropped or duplicated; output order equals input order.
- Packing:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Range checks set out_err; the word is still emitted using truncated immediate bits:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal, imm[0]=0.
  - U: imm[11:0]=0.
  - J: imm[31:20] all equal, imm[0]=0.
  - R: never errors.
  - Illegal fmt: out_instr=0, out_err=1.
- Address:
  - out_addr advances by 4 on each output handshake (out_valid & out_ready).
  - Wraps modulo 2^ADDR_W.
  - addr_clr forces out_addr=BASE_ADDR next cycle and wins over a simultaneous handshake increment. Pipeline contents are untouched.
- err_cnt: increments on each output handshake with out_err=1, saturates at 255, cleared only by reset.
- Stall: while out_valid & !out_ready, out_instr/out_addr/out_err stay stable. A new word is accepted into S1 only if S1 is empty or advancing.
- rst_n assertion mid-operation: both stages flush immediately (async). No partial word emitted after release.

Decomposition:
- common_params gains:
  - imm_fmt_t enum (FMT_R..FMT_J)
  - opcode localparams (OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL)
- One combinational sub-module, imm_pack: fmt + fields + imm → word + err. Instantiated between S1 and S2 and unit-testable standalone.

Test Plan:
- I-type: fmt=1, opcode=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF, out_ready=1 → 2 cycles later out_instr=0xFFF00093, out_err=0, out_addr=0x0000.
- S then B back-to-back:
  - S: opcode=0x23, f3=2, rs1=3, rs2=2, imm=8 → 0x0021A423 @0x0000.
  - B: opcode=0x63, f3=0, rs1=rs2=0, imm=0xFFFFFFFC → 0xFE000EE3 @0x0004, on consecutive cycles.
- J-type: opcode=0x6F, rd=1, imm=0x800 → 0x001000EF, out_err=0.
- Range errors:
  - I with imm=0x800 → 0x80000093, out_err=1.
  - B with imm=0x3 → out_err=1.
  - After both accepted, err_cnt=2.
- Backpressure: hold out_ready=0, push 3 bundles → in_ready drops after 2 accepted. out_instr is stable. Releasing out_ready yields all 3 in order at 0x0, 0x4, 0x8.
- addr_clr: after 3 words, pulse addr_clr in the same cycle as a handshake → next word at BASE_ADDR.
- Mid-stream reset: pulse rst_n low with both stages full → outputs at reset values, err_cnt=0.
